load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WIDTH, 32, data/address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, 255, max cycles waiting for mem_ack before abort; range 1..255.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  execute stage offers an access.
REQ-006 req_ready  out  1  unit accepts an access this cycle.
REQ-007 is_store  in  1  1 = store, 0 = load.
REQ-008 funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 addr  in  WIDTH  byte address, taken from the ALU result.
REQ-010 wdata  in  WIDTH  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 rdata  out  WIDTH  extended load data, valid with resp_valid.
REQ-013 err  out  1  access faulted (misaligned, illegal funct3, timeout), valid with resp_valid.
REQ-014 mem_req, mem_we  out  1 each  bus request, write enable.
REQ-015 mem_addr  out  WIDTH  word address, bits [1:0] = 0.
REQ-016 mem_be  out  4  byte enables; mem_wdata  out  WIDTH  lane-shifted store data.
REQ-017 mem_ack  in  1  bus completion; mem_rdata  in  WIDTH  read word, valid with mem_ack.

Function
REQ-018 FSM states IDLE, BUS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: req_valid=1 registers is_store, funct3, addr, wdata; next BUS, or RESP with err=1 if the access faults.
REQ-020 BUS: mem_req=1 with stable mem_we/mem_addr/mem_be/mem_wdata until the cycle mem_ack=1, then RESP.
REQ-021 RESP: resp_valid=1 for exactly one cycle, then IDLE; best-case accept-to-resp_valid latency 2 cycles (mem_ack in first BUS cycle).
REQ-022 mem_be: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-023 mem_wdata: byte replicated on all four lanes for B, halfword on both halves for H, unchanged for W.
REQ-024 Loads: selected byte/halfword of mem_rdata sign-extended for B/H, zero-extended for BU/HU; W unchanged; result registered into rdata.
REQ-025 funct3 011, 110, 111, and BU/HU with is_store=1, SHALL fault: no bus request, err=1.
REQ-026 Timeout counter: cleared on entry to BUS; on reaching TIMEOUT without mem_ack, mem_req drops, state goes to RESP with err=1, rdata=0.
REQ-027 mem_ack outside BUS SHALL be ignored.
REQ-028 rdata and err SHALL hold their values until the next RESP; rdata=0 for stores and faulted accesses.

Reset
REQ-029 rst_n=0 forces IDLE immediately, including mid-BUS; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, rdata=0, err=0, counter=0.
REQ-030 After rst_n rises, req_ready=1 on the first clock edge; a bus access aborted by reset SHALL NOT produce resp_valid.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, faults per REQ-019 with no bus request.
REQ-032 Macro undefined: misaligned addresses SHALL be force-aligned (H: addr[0] ignored; W: addr[1:0] ignored), the access proceeds, and err is never set for misalignment.

Verification
REQ-033 LB addr=0x1003, mem_rdata=0x80FF_0000, ack in first BUS cycle -> mem_be=1000, rdata=0xFFFF_FF80, err=0, resp_valid 2 cycles after accept.
REQ-034 SH addr=0x2002, wdata=0x0000_BEEF -> mem_addr=0x2000, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1.
REQ-035 LW addr=0x3001 -> with LSU_MISALIGN_TRAP_EN: no mem_req, resp_valid with err=1; without: mem_addr=0x3000, mem_be=1111, err=0.
REQ-036 LHU addr=0x10, mem_ack never asserted, TIMEOUT=4 -> mem_req high 4 cycles, then resp_valid with err=1, rdata=0.
REQ-037 rst_n pulsed low during BUS -> mem_req=0 asynchronously, no resp_valid, req_ready=1 after release; next LBU addr=0x1, mem_rdata=0x0000_9A00 -> rdata=0x0000_009A.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns, lane-shifts and extends accesses over a simple req/ack bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OFF_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_err;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [WIDTH-1:0]   r_mem_addr;
    logic [3:0]         r_mem_be;
    logic [WIDTH-1:0]   r_mem_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic [OFF_W-1:0]   r_off;
    logic               r_is_store;

    logic               w_is_b;
    logic               w_is_h;
    logic               w_is_w;
    logic               w_illegal;
    logic               w_misalign;
    logic               w_fault;
    logic [OFF_W-1:0]   w_off;
    logic [3:0]         w_be;
    logic [WIDTH-1:0]   w_wdata;
    logic [WIDTH-1:0]   w_shift;
    logic [WIDTH-1:0]   w_load;

    // Request decode: size, legality, effective byte offset, lane enables and store data.
    always_comb begin
        w_is_b    = (funct3 == 3'b000) || (funct3 == 3'b100);
        w_is_h    = (funct3 == 3'b001) || (funct3 == 3'b101);
        w_is_w    = (funct3 == 3'b010);
        w_illegal = !(w_is_b || w_is_h || w_is_w) || (is_store && funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = (w_is_h && addr[0]) || (w_is_w && (addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_fault = w_illegal || w_misalign;

        w_off   = addr[1:0];
        w_be    = 4'b1111;
        w_wdata = wdata;
        if (w_is_b) begin
            w_be    = 4'(4'b0001 << w_off);
            w_wdata = {4{wdata[7:0]}};
        end else if (w_is_h) begin
            // Halfwords ignore addr[0] so a misaligned access lands on its containing half.
            w_off   = {addr[1], 1'b0};
            w_be    = 4'(4'b0011 << w_off);
            w_wdata = {2{wdata[15:0]}};
        end else if (w_is_w) begin
            w_off = 2'b00;
        end
    end

    // Load extraction from the returned word using the registered size and offset.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{(WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{(WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {{(WIDTH-8){1'b0}}, w_shift[7:0]};
            3'b101:  w_load = {{(WIDTH-16){1'b0}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_cnt        <= '0;
            r_funct3     <= '0;
            r_off        <= '0;
            r_is_store   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3    <= funct3;
                        r_off       <= w_off;
                        r_is_store  <= is_store;
                        r_req_ready <= 1'b0;
                        if (w_fault) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                            r_rdata      <= '0;
                        end else begin
                            r_state     <= S_BUS;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= is_store;
                            r_mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_cnt       <= '0;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack) begin
                        r_state      <= S_RESP;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_err        <= 1'b0;
                        r_rdata      <= r_is_store ? '0 : w_load;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state      <= S_RESP;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_err        <= 1'b1;
                        r_rdata      <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_mem_req    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign rdata      = r_rdata;
    assign err        = r_err;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4); honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_pass;
    int n_total;

    load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for IDLE, presents one request for one accepting edge, then withdraws it.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int k;
        k = 0;
        while (!req_ready && k < 10) begin
            tick();
            k++;
        end
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_total++; if (mem_req !== 1'b0 || mem_be !== 4'b0000 || mem_addr !== 32'h0) $display("FAIL reset_bus got req=%b be=%b addr=%h exp 0/0000/0", mem_req, mem_be, mem_addr); else n_pass++;
        n_total++; if (resp_valid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) $display("FAIL reset_resp got rv=%b rdata=%h err=%b exp 0/0/0", resp_valid, rdata, err); else n_pass++;
        #4 rst_n = 1'b1;
        tick();
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_ack_ignored();
        logic seen;
        seen = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid || mem_req) seen = 1'b1;
        end
        mem_ack = 1'b0;
        n_total++; if (seen !== 1'b0 || req_ready !== 1'b1) $display("FAIL ack_idle got spurious=%b ready=%b exp 0/1", seen, req_ready); else n_pass++;
    endtask

    task automatic test_load_byte();
        issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_1000) $display("FAIL lb_bus got req=%b we=%b addr=%h exp 1/0/00001000", mem_req, mem_we, mem_addr); else n_pass++;
        n_total++; if (mem_be !== 4'b1000 || req_ready !== 1'b0) $display("FAIL lb_be got be=%b ready=%b exp 1000/0", mem_be, req_ready); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
        tick();
        mem_ack = 1'b0;
        n_total++; if (resp_valid !== 1'b1 || mem_req !== 1'b0) $display("FAIL lb_latency got rv=%b req=%b exp 1/0", resp_valid, mem_req); else n_pass++;
        n_total++; if (rdata !== 32'hFFFF_FF80 || err !== 1'b0) $display("FAIL lb_data got rdata=%h err=%b exp ffffff80/0", rdata, err); else n_pass++;
        tick();
        n_total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || rdata !== 32'hFFFF_FF80) $display("FAIL lb_hold got rv=%b ready=%b rdata=%h exp 0/1/ffffff80", resp_valid, req_ready, rdata); else n_pass++;
    endtask

    task automatic test_store_half();
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
        n_total++; if (mem_addr !== 32'h0000_2000 || mem_be !== 4'b1100 || mem_we !== 1'b1) $display("FAIL sh_bus got addr=%h be=%b we=%b exp 00002000/1100/1", mem_addr, mem_be, mem_we); else n_pass++;
        n_total++; if (mem_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_wdata got %h exp beefbeef", mem_wdata); else n_pass++;
        tick();
        n_total++; if (mem_req !== 1'b1 || mem_wdata !== 32'hBEEF_BEEF || mem_be !== 4'b1100) $display("FAIL sh_stable got req=%b wdata=%h be=%b exp 1/beefbeef/1100", mem_req, mem_wdata, mem_be); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        n_total++; if (resp_valid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) $display("FAIL sh_resp got rv=%b rdata=%h err=%b exp 1/0/0", resp_valid, rdata, err); else n_pass++;
    endtask

    task automatic test_misaligned_word();
        issue(1'b0, 3'b010, 32'h0000_3001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_total++; if (mem_req !== 1'b0 || resp_valid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) $display("FAIL lw_mis got req=%b rv=%b err=%b rdata=%h exp 0/1/1/0", mem_req, resp_valid, err, rdata); else n_pass++;
`else
        n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000 || mem_be !== 4'b1111) $display("FAIL lw_mis got req=%b addr=%h be=%b exp 1/00003000/1111", mem_req, mem_addr, mem_be); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        n_total++; if (resp_valid !== 1'b1 || rdata !== 32'h1234_5678 || err !== 1'b0) $display("FAIL lw_mis_resp got rv=%b rdata=%h err=%b exp 1/12345678/0", resp_valid, rdata, err); else n_pass++;
`endif
    endtask

    task automatic test_illegal();
        issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
        n_total++; if (mem_req !== 1'b0 || resp_valid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) $display("FAIL f3_011 got req=%b rv=%b err=%b rdata=%h exp 0/1/1/0", mem_req, resp_valid, err, rdata); else n_pass++;
        issue(1'b1, 3'b100, 32'h0000_0040, 32'h55);
        n_total++; if (mem_req !== 1'b0 || resp_valid !== 1'b1 || err !== 1'b1) $display("FAIL store_bu got req=%b rv=%b err=%b exp 0/1/1", mem_req, resp_valid, err); else n_pass++;
        tick();
        n_total++; if (err !== 1'b1 || resp_valid !== 1'b0) $display("FAIL err_hold got err=%b rv=%b exp 1/0", err, resp_valid); else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc;
        issue(1'b0, 3'b101, 32'h0000_0010, 32'h0);
        cyc = 0;
        while (mem_req && cyc < 20) begin
            cyc++;
            tick();
        end
        n_total++; if (cyc !== 4) $display("FAIL to_cycles got %0d exp 4", cyc); else n_pass++;
        n_total++; if (resp_valid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) $display("FAIL to_resp got rv=%b err=%b rdata=%h exp 1/1/0", resp_valid, err, rdata); else n_pass++;
    endtask

    task automatic test_reset_mid_bus();
        logic seen;
        issue(1'b0, 3'b010, 32'h0000_0000, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        n_total++; if (mem_req !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_async got req=%b ready=%b exp 0/1", mem_req, req_ready); else n_pass++;
        #3 rst_n = 1'b1;
        seen = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        mem_ack = 1'b0;
        n_total++; if (seen !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_noresp got rv_seen=%b ready=%b exp 0/1", seen, req_ready); else n_pass++;
        issue(1'b0, 3'b100, 32'h0000_0001, 32'h0);
        n_total++; if (mem_be !== 4'b0010 || mem_addr !== 32'h0) $display("FAIL lbu_bus got be=%b addr=%h exp 0010/0", mem_be, mem_addr); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h0000_9A00;
        tick();
        mem_ack = 1'b0;
        n_total++; if (resp_valid !== 1'b1 || rdata !== 32'h0000_009A || err !== 1'b0) $display("FAIL lbu_resp got rv=%b rdata=%h err=%b exp 1/0000009a/0", resp_valid, rdata, err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 3'b000, 32'h0000_0005, 32'h1234_56A5);
        n_total++; if (mem_be !== 4'b0010 || mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_bus got be=%b wdata=%h exp 0010/a5a5a5a5", mem_be, mem_wdata); else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        issue(1'b0, 3'b001, 32'h0000_0006, 32'h0);
        n_total++; if (mem_be !== 4'b1100 || mem_we !== 1'b0) $display("FAIL lh_bus got be=%b we=%b exp 1100/0", mem_be, mem_we); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h8001_7FFF;
        tick();
        mem_ack = 1'b0;
        n_total++; if (rdata !== 32'hFFFF_8001) $display("FAIL lh_sext got %h exp ffff8001", rdata); else n_pass++;
        issue(1'b0, 3'b001, 32'h0000_0007, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_total++; if (mem_req !== 1'b0 || err !== 1'b1 || resp_valid !== 1'b1) $display("FAIL lh_mis got req=%b err=%b rv=%b exp 0/1/1", mem_req, err, resp_valid); else n_pass++;
`else
        n_total++; if (mem_req !== 1'b1 || mem_be !== 4'b1100) $display("FAIL lh_mis got req=%b be=%b exp 1/1100", mem_req, mem_be); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h7FFE_0000;
        tick();
        mem_ack = 1'b0;
        n_total++; if (rdata !== 32'h0000_7FFE || err !== 1'b0) $display("FAIL lh_mis_resp got rdata=%h err=%b exp 00007ffe/0", rdata, err); else n_pass++;
`endif
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_ack_ignored();
        test_load_byte();
        test_store_half();
        test_misaligned_word();
        test_illegal();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
